bcd_to_binary: RTL and testbench
================================

BCD_TO_BINARY -- requirements
Module: bcd_to_binary

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 bcd_input  input  4  one BCD digit, 0-9 legal, 10-15 illegal.
REQ-005 in_valid  input  1  bcd_input is presented this cycle.
REQ-006 first  input  1  qualified by in_valid; digit starts a new number (most-significant digit).
REQ-007 binary_output  output  8  registered unsigned binary value of the digits accumulated so far.
REQ-008 out_valid  output  1  one-cycle pulse; binary_output updated by an accepted digit.
REQ-009 digit_err  output  1  one-cycle pulse; an illegal digit was presented.
REQ-010 overflow  output  1  sticky; the current number exceeded 255.
REQ-011 The block SHALL have one clock (clk) and a synchronous, active-high reset (rst); no other clock or asynchronous input.

Function
REQ-012 Digits SHALL arrive most-significant first, one per in_valid cycle; no backpressure, every in_valid cycle is consumed.
REQ-013 Accepted digit, first=1: accumulator SHALL become the digit value; overflow SHALL clear.
REQ-014 Accepted digit, first=0: accumulator SHALL become accumulator*10 + digit, computed at least 12 bits wide.
REQ-015 If the REQ-014 result exceeds 255, accumulator SHALL saturate to 255 and overflow SHALL set.
REQ-016 While overflow=1 and first=0, accepted digits SHALL leave the accumulator at 255.
REQ-017 overflow SHALL remain set until an accepted digit with first=1, or until reset.
REQ-018 binary_output SHALL equal the accumulator register, updated one clock after the accepting edge (latency 1).
REQ-019 out_valid SHALL pulse high for exactly the cycle in which binary_output shows the new value.
REQ-020 bcd_input > 9 with in_valid=1: digit_err SHALL pulse one cycle (same latency as out_valid).
REQ-021 On that illegal digit, out_valid SHALL stay 0, and accumulator and overflow SHALL be unchanged, including when first=1.
REQ-022 in_valid=0: no state change; out_valid and digit_err SHALL be 0; bcd_input and first are ignored.
REQ-023 Single-digit numbers SHALL map identically: digit d with first=1 gives binary_output = d (0 to 00000000, 5 to 00000101, 9 to 00001001).
REQ-024 No internal limit on digit count other than saturation; a number ends implicitly at the next first=1.

Reset
REQ-025 rst=1 at a rising edge SHALL clear accumulator, binary_output, out_valid, digit_err and overflow to 0; rst takes priority over in_valid.
REQ-026 A digit presented in the same cycle as rst SHALL be discarded.
REQ-027 Reset mid-number SHALL discard the partial number; the next accepted digit with first=0 SHALL accumulate onto 0.

Verification
REQ-028 Digits 0..9 each with in_valid=1 and first=1 -> binary_output = 0..9 one cycle later, out_valid pulse each, digit_err=0.
REQ-029 Sequence 2(first),5,5 -> binary_output 2, 25, 255; overflow=0.
REQ-030 Sequence 2(first),5,6 -> 2, 25, then 255 with overflow=1; then 7(first) -> 7, overflow=0.
REQ-031 bcd_input 1010..1111 with in_valid=1, first=1 after value 42 -> digit_err pulse each; binary_output stays 42; out_valid=0.
REQ-032 rst mid-sequence 4(first),2 then rst, then 3(first=0) -> all outputs 0 after reset; then binary_output=3.
REQ-033 in_valid=0 with random bcd_input and first -> outputs hold; no pulses.

Source files
------------

// File: rtl/bcd_to_binary.sv
// Serial BCD-to-binary converter: accumulates decimal digits (MSD first) into a
// saturating 8-bit value with registered outputs and one-cycle status pulses.
module bcd_to_binary (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bcd_input,
  input  logic       in_valid,
  input  logic       first,
  output logic [7:0] binary_output,
  output logic       out_valid,
  output logic       digit_err,
  output logic       overflow
);

  logic [7:0]  acc_reg, acc_next;
  logic        overflow_reg, overflow_next;
  logic        out_valid_reg, out_valid_next;
  logic        digit_err_reg, digit_err_next;
  logic        digit_legal;
  logic [11:0] times_ten;
  logic [11:0] scaled_sum;

  assign digit_legal = (bcd_input <= 4'd9);

  // acc*10 as (acc<<3)+(acc<<1), kept 12 bits wide so 255*10+9 never wraps.
  assign times_ten  = ({4'd0, acc_reg} << 3) + ({4'd0, acc_reg} << 1);
  assign scaled_sum = times_ten + {8'd0, bcd_input};

  always_comb begin
    acc_next       = acc_reg;
    overflow_next  = overflow_reg;
    out_valid_next = 1'b0;
    digit_err_next = 1'b0;
    if (in_valid) begin
      if (!digit_legal) begin
        // Illegal digit leaves the number untouched, even when it claims to start one.
        digit_err_next = 1'b1;
      end else begin
        out_valid_next = 1'b1;
        if (first) begin
          acc_next      = {4'd0, bcd_input};
          overflow_next = 1'b0;
        end else if (overflow_reg) begin
          acc_next = 8'hFF;
        end else if (scaled_sum > 12'd255) begin
          acc_next      = 8'hFF;
          overflow_next = 1'b1;
        end else begin
          acc_next = scaled_sum[7:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_reg       <= 8'd0;
      overflow_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      digit_err_reg <= 1'b0;
    end else begin
      acc_reg       <= acc_next;
      overflow_reg  <= overflow_next;
      out_valid_reg <= out_valid_next;
      digit_err_reg <= digit_err_next;
    end
  end

  assign binary_output = acc_reg;
  assign out_valid     = out_valid_reg;
  assign digit_err     = digit_err_reg;
  assign overflow      = overflow_reg;

endmodule

// File: tb/tb_bcd_to_binary.sv
// Self-checking bench for bcd_to_binary: directed scenarios plus random digit
// streams compared against a decimal-arithmetic reference model.
module tb_bcd_to_binary;

  logic       clk;
  logic       rst;
  logic [3:0] bcd_input;
  logic       in_valid;
  logic       first;
  logic [7:0] binary_output;
  logic       out_valid;
  logic       digit_err;
  logic       overflow;

  int n_compared;
  int n_mismatched;

  // Reference model state: the number as a plain integer plus sticky overflow.
  int model_value;
  bit model_ovf;
  bit model_out_valid;
  bit model_digit_err;

  bcd_to_binary dut (
    .clk           (clk),
    .rst           (rst),
    .bcd_input     (bcd_input),
    .in_valid      (in_valid),
    .first         (first),
    .binary_output (binary_output),
    .out_valid     (out_valid),
    .digit_err     (digit_err),
    .overflow      (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input int d, input bit v, input bit f);
    model_out_valid = 1'b0;
    model_digit_err = 1'b0;
    if (!v) return;
    if (d > 9) begin
      model_digit_err = 1'b1;
      return;
    end
    model_out_valid = 1'b1;
    if (f) begin
      model_value = d;
      model_ovf   = 1'b0;
    end else if (model_ovf) begin
      model_value = 255;
    end else if (model_value * 10 + d > 255) begin
      model_value = 255;
      model_ovf   = 1'b1;
    end else begin
      model_value = model_value * 10 + d;
    end
  endtask

  task automatic check_outputs(input string tag);
    check_val({tag, ".binary_output"}, {24'd0, binary_output}, model_value);
    check_val({tag, ".out_valid"},     {31'd0, out_valid},     {31'd0, model_out_valid});
    check_val({tag, ".digit_err"},     {31'd0, digit_err},     {31'd0, model_digit_err});
    check_val({tag, ".overflow"},      {31'd0, overflow},      {31'd0, model_ovf});
  endtask

  // One clock of stimulus; inputs change on the falling edge, outputs sampled after the rising edge.
  task automatic apply(input logic [3:0] d, input bit v, input bit f, input string tag);
    @(negedge clk);
    bcd_input = d;
    in_valid  = v;
    first     = f;
    @(posedge clk);
    #1;
    model_step(int'(d), v, f);
    $display("txn %-8s v=%0d f=%0d d=%0d -> out=%0d ov=%0d err=%0d ovf=%0d", tag, v, f, d,
             binary_output, out_valid, digit_err, overflow);
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst       = 1'b1;
    in_valid  = 1'b1;
    first     = 1'b0;
    bcd_input = 4'($urandom_range(0, 9));
    @(posedge clk);
    #1;
    model_value     = 0;
    model_ovf       = 1'b0;
    model_out_valid = 1'b0;
    model_digit_err = 1'b0;
    $display("txn %-8s reset -> out=%0d ov=%0d err=%0d ovf=%0d", tag,
             binary_output, out_valid, digit_err, overflow);
    check_outputs(tag);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    model_value  = 0;
    model_ovf    = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    first     = 1'b0;
    bcd_input = 4'd0;
    repeat (2) @(posedge clk);
    do_reset("reset");

    // Single digits map identically.
    for (int i = 0; i < 10; i++) begin
      apply(4'(i), 1'b1, 1'b1, "single");
      check_val("single.value", {24'd0, binary_output}, i);
    end

    // 2,5,5 lands exactly on 255 without overflow.
    apply(4'd2, 1'b1, 1'b1, "seq255");
    apply(4'd5, 1'b1, 1'b0, "seq255");
    apply(4'd5, 1'b1, 1'b0, "seq255");
    check_val("seq255.value", {24'd0, binary_output}, 255);
    check_val("seq255.no_ovf", {31'd0, overflow}, 0);

    // 2,5,6 saturates; extra digits hold 255; new first clears.
    apply(4'd2, 1'b1, 1'b1, "seq256");
    apply(4'd5, 1'b1, 1'b0, "seq256");
    apply(4'd6, 1'b1, 1'b0, "seq256");
    check_val("seq256.sat", {24'd0, binary_output}, 255);
    check_val("seq256.ovf", {31'd0, overflow}, 1);
    apply(4'd0, 1'b1, 1'b0, "sathold");
    apply(4'd7, 1'b1, 1'b1, "restart");
    check_val("restart.value", {24'd0, binary_output}, 7);
    check_val("restart.ovf", {31'd0, overflow}, 0);

    // Illegal digits after 42, with first=1, must not disturb the value.
    apply(4'd4, 1'b1, 1'b1, "v42");
    apply(4'd2, 1'b1, 1'b0, "v42");
    for (int i = 10; i < 16; i++) begin
      apply(4'(i), 1'b1, 1'b1, "illegal");
      check_val("illegal.hold", {24'd0, binary_output}, 42);
    end

    // Illegal digit while overflowed must not clear overflow.
    apply(4'd9, 1'b1, 1'b1, "ovfill");
    apply(4'd9, 1'b1, 1'b0, "ovfill");
    apply(4'd9, 1'b1, 1'b0, "ovfill");
    apply(4'd12, 1'b1, 1'b1, "ovfill");

    // Reset mid-number, then accumulate onto zero.
    apply(4'd4, 1'b1, 1'b1, "midrst");
    apply(4'd2, 1'b1, 1'b0, "midrst");
    do_reset("midrst");
    apply(4'd3, 1'b1, 1'b0, "postrst");
    check_val("postrst.value", {24'd0, binary_output}, 3);

    // Idle cycles with random inputs hold state.
    for (int i = 0; i < 10; i++)
      apply(4'($urandom_range(0, 15)), 1'b0, 1'($urandom_range(0, 1)), "idle");

    // Random streams, biased towards legal digits and multi-digit numbers.
    for (int i = 0; i < 400; i++) begin
      logic [3:0] d;
      bit v, f;
      v = ($urandom_range(0, 3) != 0);
      f = ($urandom_range(0, 4) == 0);
      d = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      if ($urandom_range(0, 99) == 0) do_reset("rndrst");
      else apply(d, v, f, "random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
